// File: rtl/rca_chunk_sequencer.sv
// Purpose : WIDTH-bit adder that walks one shared 4-bit ripple adder over the operands, LSB slice first.
// Latency : out_valid rises CHUNKS cycles after the accepting edge; one result per CHUNKS+2 cycles at best.
// Backpres: in_ready only in IDLE; out_ready low holds DONE with sum/cout frozen indefinitely.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b, cin)
//   out_valid/out_ready  result handshake (sum, cout)
//   busy                 high whenever the sequencer is not IDLE
//
// WIDTH must be a multiple of 4 and at least 8, so CHUNKS >= 2 and idx is at least 1 bit wide.

module ripple_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];
endmodule

module rca_chunk_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CHUNKS = WIDTH / 4;
  localparam int IW     = $clog2(CHUNKS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;

  logic [3:0]       a_sl;
  logic [3:0]       b_sl;
  logic [3:0]       add_s;
  logic             add_co;
  logic             last_chunk;

  // The adder is always fed the current slice; its output is only consumed in RUN.
  assign a_sl       = a_reg[4*idx +: 4];
  assign b_sl       = b_reg[4*idx +: 4];
  assign last_chunk = (idx == IW'(CHUNKS - 1));

  ripple_adder u_add (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry_reg),
    .s  (add_s),
    .co (add_co)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= add_s;
          carry_reg       <= add_co;
          if (last_chunk) begin
            cout  <= add_co;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
